// File: rtl/engine_sound_pkg.sv
// Shared constants and helpers for the multi-channel engine-noise voice.
package engine_sound_pkg;

    localparam int unsigned CH_W  = 4;
    localparam logic [3:0]  CH_MAX = 4'd15;
    localparam int unsigned OUT_W = 16;

    localparam logic [7:0] DEF_LOOP_START = {4'd11, 4'd9};
    localparam logic [7:0] DEF_INIT_VAL   = {4'd6, 4'd4};

    // Width that holds the sum of num_ch full-scale 4-bit channels.
    function automatic int unsigned sum_width(input int unsigned num_ch);
        if (num_ch <= 1)
            return CH_W;
        return CH_W + $clog2(num_ch);
    endfunction

endpackage

// File: rtl/engine_ring_counter.sv
// One 4-bit engine ring channel: counts up to 15, then reloads its loop start.
module engine_ring_counter
    import engine_sound_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            step,
    input  logic            restart,
    input  logic [CH_W-1:0] loop_start,
    input  logic [CH_W-1:0] init_val,
    output logic [CH_W-1:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= init_val;
        end else if (en) begin
            if (restart)
                value <= '0;
            else if (step)
                value <= (value == CH_MAX) ? loop_start : value + CH_W'(1);
        end
    end

endmodule

// File: rtl/engine_sound_multi.sv
// N-channel engine-noise generator with slewed CV-controlled period.
// Define ENGINE_SOUND_MULTI_IIR_EN to add a one-pole low-pass on the output.
module engine_sound_multi
    import engine_sound_pkg::*;
#(
    parameter int unsigned              NUM_CH     = 2,
    parameter int unsigned              CV_W       = 8,
    parameter int unsigned              RAMP_DIV   = 4096,
    parameter int unsigned              RISE_STEP  = 1,
    parameter int unsigned              FALL_STEP  = 1,
    parameter logic [31:0]              WL_BASE    = 32'd6000,
    parameter logic [31:0]              WL_SLOPE   = 32'd20,
    parameter logic [31:0]              WL_MIN     = 32'd200,
    parameter logic [NUM_CH*CH_W-1:0]   LOOP_START = (NUM_CH*CH_W)'(DEF_LOOP_START),
    parameter logic [NUM_CH*CH_W-1:0]   INIT_VAL   = (NUM_CH*CH_W)'(DEF_INIT_VAL)
`ifdef ENGINE_SOUND_MULTI_IIR_EN
    ,
    parameter int unsigned              IIR_SHIFT  = 8
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_3MHz_en,
    input  logic             engine_rev_en,
    input  logic             motor_en,
    output logic [OUT_W-1:0] out
);

    localparam int unsigned     RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam int unsigned     SUM_W  = sum_width(NUM_CH);
    localparam logic [CV_W-1:0] CV_MAX = '1;

    logic [RAMP_W-1:0] ramp_cnt;
    logic [CV_W-1:0]   cv, cv_next;
    logic [31:0]       wave_len, wl_prod, wl_next, period_cnt;
    logic              last_motor, step, restart;
    logic [CH_W-1:0]   ch_val [NUM_CH];
    logic [SUM_W-1:0]  sum;
    logic [OUT_W-1:0]  mix;

    assign step    = (period_cnt >= wave_len);
    assign restart = motor_en & ~last_motor;

    always_comb begin
        if (engine_rev_en)
            cv_next = (32'(cv) + RISE_STEP > 32'(CV_MAX)) ? CV_MAX : cv + CV_W'(RISE_STEP);
        else
            cv_next = (32'(cv) < FALL_STEP) ? '0 : cv - CV_W'(FALL_STEP);
    end

    // Test the product against the base before subtracting so the result never wraps.
    always_comb begin
        wl_prod = 32'(cv) * WL_SLOPE;
        if (wl_prod >= WL_BASE)
            wl_next = WL_MIN;
        else if (WL_BASE - wl_prod < WL_MIN)
            wl_next = WL_MIN;
        else
            wl_next = WL_BASE - wl_prod;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_cnt   <= '0;
            cv         <= '0;
            wave_len   <= WL_BASE;
            period_cnt <= '0;
            last_motor <= 1'b0;
        end else if (clk_3MHz_en) begin
            last_motor <= motor_en;
            wave_len   <= wl_next;
            if (ramp_cnt == RAMP_W'(RAMP_DIV - 1)) begin
                ramp_cnt <= '0;
                cv       <= cv_next;
            end else begin
                ramp_cnt <= ramp_cnt + RAMP_W'(1);
            end
            if (restart || step)
                period_cnt <= '0;
            else
                period_cnt <= period_cnt + 32'd1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        engine_ring_counter u_ch (
            .clk        (clk),
            .rst        (rst),
            .en         (clk_3MHz_en),
            .step       (step),
            .restart    (restart),
            .loop_start (LOOP_START[k*CH_W +: CH_W]),
            .init_val   (INIT_VAL[k*CH_W +: CH_W]),
            .value      (ch_val[k])
        );
    end

    always_comb begin
        sum = '0;
        for (int unsigned k = 0; k < NUM_CH; k++)
            sum = sum + SUM_W'(ch_val[k]);
    end

    always_ff @(posedge clk) begin
        if (rst)
            mix <= '0;
        else
            mix <= motor_en ? {sum, {(OUT_W-SUM_W){1'b0}}} : '0;
    end

`ifdef ENGINE_SOUND_MULTI_IIR_EN
    localparam int unsigned Y_W = OUT_W + IIR_SHIFT;
    logic [Y_W-1:0] y;

    // Decay term is removed before adding mix so y stays within Y_W bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            y   <= '0;
            out <= '0;
        end else begin
            if (clk_3MHz_en)
                y <= (y - (y >> IIR_SHIFT)) + Y_W'(mix);
            out <= OUT_W'(y >> IIR_SHIFT);
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst)
            out <= '0;
        else
            out <= mix;
    end
`endif

endmodule

// File: tb/tb_engine_sound_multi.sv
// Directed self-checking bench for engine_sound_multi across several parameter sets.
module tb_engine_sound_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        en_d, rev_d, mot_d;
    logic        en_f, rev_f, mot_f;
    logic        en_s, rev_s, mot_s;
    logic        en_w, rev_w, mot_w;
    logic        en_i, rev_i, mot_i;
    logic [15:0] out_d, out_f, out_s, out_w, out_i;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    engine_sound_multi u_def (
        .clk(clk), .rst(rst), .clk_3MHz_en(en_d), .engine_rev_en(rev_d),
        .motor_en(mot_d), .out(out_d)
    );

    engine_sound_multi #(.RAMP_DIV(2)) u_fast (
        .clk(clk), .rst(rst), .clk_3MHz_en(en_f), .engine_rev_en(rev_f),
        .motor_en(mot_f), .out(out_f)
    );

    engine_sound_multi #(.WL_BASE(32'd3), .WL_MIN(32'd3)) u_step (
        .clk(clk), .rst(rst), .clk_3MHz_en(en_s), .engine_rev_en(rev_s),
        .motor_en(mot_s), .out(out_s)
    );

    engine_sound_multi #(
        .NUM_CH(4), .RAMP_DIV(1), .WL_SLOPE(32'd100),
        .LOOP_START(16'hFFFF), .INIT_VAL(16'hFFFF)
    ) u_wide (
        .clk(clk), .rst(rst), .clk_3MHz_en(en_w), .engine_rev_en(rev_w),
        .motor_en(mot_w), .out(out_w)
    );

    engine_sound_multi #(
        .WL_BASE(32'd0), .WL_MIN(32'd0), .LOOP_START(8'hFF), .INIT_VAL(8'h00)
    ) u_iir (
        .clk(clk), .rst(rst), .clk_3MHz_en(en_i), .engine_rev_en(rev_i),
        .motor_en(mot_i), .out(out_i)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int unsigned e0, e1, mono_bad, over;
    logic [15:0] prev, exp_w_out;

    initial begin
        rst = 1'b1;
        {en_d, rev_d, mot_d, en_f, rev_f, mot_f, en_s, rev_s, mot_s} = '0;
        {en_w, rev_w, mot_w, en_i, rev_i, mot_i} = '0;
        tick(3);

        // reset state
        check("rst_out",  32'(out_d), 0);
        check("rst_cv",   32'(u_def.cv), 0);
        check("rst_wl",   u_def.wave_len, 6000);
        check("rst_ch0",  32'(u_def.ch_val[0]), 4);
        check("rst_ch1",  32'(u_def.ch_val[1]), 6);
        check("rst_pcnt", u_def.period_cnt, 0);

        // idle with revs off: cv floors at 0, counters hold
        rst  = 1'b0;
        en_d = 1'b1;
        tick(10);
        check("idle_cv",   32'(u_def.cv), 0);
        check("idle_ramp", 32'(u_def.ramp_cnt), 10);
        check("idle_wl",   u_def.wave_len, 6000);
        check("idle_pcnt", u_def.period_cnt, 10);
        check("idle_ch0",  32'(u_def.ch_val[0]), 4);
        check("idle_ch1",  32'(u_def.ch_val[1]), 6);
        check("idle_out",  32'(out_d), 0);
        en_d = 1'b0;

        // CV slew with RAMP_DIV=2: cv = enables/2, wave_len one enable behind
        en_f = 1'b1; rev_f = 1'b1;
        tick(20);
        check("ramp_cv10",  32'(u_fast.cv), 10);
        check("ramp_wl9",   u_fast.wave_len, 5820);
        check("ramp_rcnt",  32'(u_fast.ramp_cnt), 0);
        tick(1);
        check("ramp_cvhold", 32'(u_fast.cv), 10);
        check("ramp_wl10",  u_fast.wave_len, 5800);
        tick(600);
        check("sat_cv",  32'(u_fast.cv), 255);
        check("sat_wl",  u_fast.wave_len, 900);
        tick(2);
        check("sat_nowrap", 32'(u_fast.cv), 255);
        rev_f = 1'b0;
        tick(1);
        check("fall_cv", 32'(u_fast.cv), 254);
        tick(600);
        check("floor_cv", 32'(u_fast.cv), 0);
        check("floor_wl", u_fast.wave_len, 6000);
        en_f = 1'b0;

        // motor restart then stepping every 4 enables
        mot_s = 1'b1; en_s = 1'b1;
        tick(1);
        check("rs_ch0",  32'(u_step.ch_val[0]), 0);
        check("rs_ch1",  32'(u_step.ch_val[1]), 0);
        check("rs_pcnt", u_step.period_cnt, 0);
        e0 = 0; e1 = 0;
        for (int i = 0; i < 26; i++) begin
            tick(3);
            check("seq_pcnt3", u_step.period_cnt, 3);
            tick(1);
            e0 = (e0 == 15) ? 9  : e0 + 1;
            e1 = (e1 == 15) ? 11 : e1 + 1;
            check("seq_ch0", 32'(u_step.ch_val[0]), e0);
            check("seq_ch1", 32'(u_step.ch_val[1]), e1);
        end

        // restart coinciding with a step: restart wins
        mot_s = 1'b0;
        tick(3);
        check("coll_pcnt3", u_step.period_cnt, 3);
        check("coll_pre0",  32'(u_step.ch_val[0]), e0);
        mot_s = 1'b1;
        tick(1);
        check("coll_ch0",  32'(u_step.ch_val[0]), 0);
        check("coll_ch1",  32'(u_step.ch_val[1]), 0);
        check("coll_pcnt", u_step.period_cnt, 0);
        tick(4);
        check("coll_next0", 32'(u_step.ch_val[0]), 1);
        en_s = 1'b0;

        // four full-scale channels, no enables: mix = 60 << 10
`ifdef ENGINE_SOUND_MULTI_IIR_EN
        exp_w_out = 16'd0;
`else
        exp_w_out = 16'd61440;
`endif
        check("wide_out0", 32'(out_w), 0);
        mot_w = 1'b1;
        tick(1);
        check("wide_mix",  32'(u_wide.mix), 61440);
        check("wide_lag",  32'(out_w), 0);
        tick(1);
        check("wide_out",  32'(out_w), 32'(exp_w_out));
        mot_w = 1'b0;
        tick(1);
        check("wide_mix0", 32'(u_wide.mix), 0);
        tick(1);
        check("wide_mute", 32'(out_w), 0);

        // period map with slope 100 down to the floor
        en_w = 1'b1; rev_w = 1'b1;
        tick(11);
        check("map_cv11", 32'(u_wide.cv), 11);
        check("map_wl10", u_wide.wave_len, 5000);
        tick(47);
        check("map_wl57", u_wide.wave_len, 300);
        tick(1);
        check("map_wl58", u_wide.wave_len, 200);
        tick(2);
        check("map_wl60", u_wide.wave_len, 200);
        tick(239);
        check("map_cvmax", 32'(u_wide.cv), 255);
        check("map_wlmax", u_wide.wave_len, 200);
        check("map_ch3",   32'(u_wide.ch_val[3]), 15);

        // continuous stepping to a held 15 on both channels
        mot_i = 1'b1; en_i = 1'b1;
        tick(20);
        check("iir_ch0", 32'(u_iir.ch_val[0]), 15);
        check("iir_ch1", 32'(u_iir.ch_val[1]), 15);
`ifdef ENGINE_SOUND_MULTI_IIR_EN
        prev = out_i; mono_bad = 0; over = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1);
            if (out_i < prev)        mono_bad++;
            if (out_i > 16'd61440)   over++;
            prev = out_i;
        end
        check("iir_mono",  mono_bad, 0);
        check("iir_over",  over, 0);
        check("iir_63pct", 32'(out_i >= 16'd38707), 1);
`else
        tick(2);
        check("full_out", 32'(out_i), 61440);
        mot_i = 1'b0;
        tick(2);
        check("full_mute", 32'(out_i), 0);
`endif

        // synchronous reset in mid-operation
        rst = 1'b1;
        tick(1);
        check("mrst_cv",   32'(u_wide.cv), 0);
        check("mrst_wl",   u_wide.wave_len, 6000);
        check("mrst_pcnt", u_wide.period_cnt, 0);
        check("mrst_ch0",  32'(u_wide.ch_val[0]), 15);
        check("mrst_out",  32'(out_w), 0);
        check("mrst_s0",   32'(u_step.ch_val[0]), 4);
        check("mrst_s1",   32'(u_step.ch_val[1]), 6);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
